// File: rtl/comp_pkg.sv
// Shared types for the sequential magnitude comparator: FSM states and the
// g/l/e cascade triple carried from slice to slice.
package comp_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  typedef struct packed {
    logic g;
    logic l;
    logic e;
  } cascade_t;

  localparam cascade_t CASCADE_SEED = '{g: 1'b0, l: 1'b0, e: 1'b1};

endpackage

// File: rtl/comparator_4bit.sv
// One 4-bit magnitude compare stage with cascade inputs; a strict ordering of
// this slice overrides whatever the lower slices decided.
module comparator_4bit (
  input  logic       en,
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       in_g,
  input  logic       in_l,
  input  logic       in_e,
  output logic       g,
  output logic       l,
  output logic       e
);

  always_comb begin
    g = in_g;
    l = in_l;
    e = in_e;
    if (en) begin
      if (a > b) begin
        g = 1'b1;
        l = 1'b0;
        e = 1'b0;
      end else if (a < b) begin
        g = 1'b0;
        l = 1'b1;
        e = 1'b0;
      end
    end
  end

endmodule

// File: rtl/comparator_seq_nibble.sv
// Sequential WIDTH-bit magnitude comparator walking SLICE-bit slices LSB-first.
// Define COMP_SIGNED_EN for a two's-complement compare (MSB flipped on the top slice).
module comparator_seq_nibble
  import comp_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             g,
  output logic             l,
  output logic             e
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam int IW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

  if (WIDTH % SLICE != 0) begin : g_bad_width
    $error("WIDTH must be a multiple of SLICE");
  end

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  cascade_t         casc_q, casc_d;
  cascade_t         res_q, res_d;
  logic             done_q, done_d;

  logic [IW-1:0]    off;
  logic [SLICE-1:0] sa, sb;
  cascade_t         slice_out;

  assign off = IW'(int'(cnt_q) * SLICE);

  always_comb begin
    sa = a_q[off +: SLICE];
    sb = b_q[off +: SLICE];
`ifdef COMP_SIGNED_EN
    // Flipping the sign bit maps two's complement onto unsigned ordering.
    if (cnt_q == LAST) begin
      sa[SLICE-1] = ~sa[SLICE-1];
      sb[SLICE-1] = ~sb[SLICE-1];
    end
`endif
  end

  if (SLICE == 4) begin : g_nibble
    comparator_4bit u_slice (
      .en   (1'b1),
      .a    (sa),
      .b    (sb),
      .in_g (casc_q.g),
      .in_l (casc_q.l),
      .in_e (casc_q.e),
      .g    (slice_out.g),
      .l    (slice_out.l),
      .e    (slice_out.e)
    );
  end else begin : g_generic
    always_comb begin
      slice_out = casc_q;
      if (sa > sb) begin
        slice_out = '{g: 1'b1, l: 1'b0, e: 1'b0};
      end else if (sa < sb) begin
        slice_out = '{g: 1'b0, l: 1'b1, e: 1'b0};
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    casc_d  = casc_q;
    res_d   = res_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start && en) begin
          state_d = RUN;
          a_d     = a;
          b_d     = b;
          casc_d  = CASCADE_SEED;
          cnt_d   = '0;
        end
      end
      RUN: begin
        if (en) begin
          casc_d = slice_out;
          if (cnt_q == LAST) begin
            state_d = DONE;
            res_d   = slice_out;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      casc_q  <= '0;
      res_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      casc_q  <= casc_d;
      res_q   <= res_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = done_q;
  assign g    = res_q.g;
  assign l    = res_q.l;
  assign e    = res_q.e;

endmodule

// File: tb/tb_comparator_seq_nibble.sv
// Directed bench for comparator_seq_nibble (WIDTH=32, SLICE=4); honours COMP_SIGNED_EN.
module tb_comparator_seq_nibble;

  logic        clk = 1'b0;
  logic        rst, en, start;
  logic [31:0] a, b;
  logic        busy, done, g, l, e;

  int nvec  = 0;
  int nfail = 0;

  comparator_seq_nibble #(.WIDTH(32), .SLICE(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .g     (g),
    .l     (l),
    .e     (e)
  );

  always #5 clk = ~clk;

  // Start one comparison, scramble the operand inputs after capture, and wait
  // (bounded) for done; lat counts edges after the accepting edge (-1 on timeout).
  task automatic run_op(input logic [31:0] av, input logic [31:0] bv,
                        output int lat, output logic [2:0] gle, output logic pulse_low);
    @(negedge clk);
    start = 1'b1; en = 1'b1; a = av; b = bv;
    @(negedge clk);
    start = 1'b0; a = ~av; b = ~bv;
    lat = 0;
    while (!done && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    if (!done) lat = -1;
    gle = {g, l, e};
    @(negedge clk);
    pulse_low = ~done;
  endtask

  task automatic test_reset;
    rst = 1'b1; en = 1'b0; start = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    nvec++;
    if ({busy, done, g, l, e} !== 5'b00000) begin
      nfail++;
      $display("FAIL reset_outputs: got busy,done,g,l,e=%b expected 00000", {busy, done, g, l, e});
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_equal;
    int lat; logic [2:0] gle; logic pl;
    run_op(32'h12345678, 32'h12345678, lat, gle, pl);
    nvec++;
    if (lat !== 8) begin nfail++; $display("FAIL equal_latency: got %0d expected 8", lat); end
    nvec++;
    if (gle !== 3'b001) begin nfail++; $display("FAIL equal_gle: got %b expected 001", gle); end
    nvec++;
    if (pl !== 1'b1) begin nfail++; $display("FAIL equal_done_pulse: done still high, expected one cycle"); end
    nvec++;
    if ({busy, g, l, e} !== 4'b0001) begin
      nfail++; $display("FAIL equal_done_hold: got busy,g,l,e=%b expected 0001", {busy, g, l, e});
    end
  endtask

  task automatic test_high_overrides;
    int lat; logic [2:0] gle; logic pl;
    run_op(32'h00000010, 32'h0000000F, lat, gle, pl);
    nvec++;
    if (lat !== 8) begin nfail++; $display("FAIL override_latency: got %0d expected 8", lat); end
    nvec++;
    if (gle !== 3'b100) begin nfail++; $display("FAIL override_gle: got %b expected 100", gle); end
    // Result must hold in DONE through stalled cycles.
    en = 1'b0;
    repeat (3) @(negedge clk);
    nvec++;
    if ({done, g, l, e} !== 4'b0100) begin
      nfail++; $display("FAIL done_hold_stall: got done,g,l,e=%b expected 0100", {done, g, l, e});
    end
  endtask

  task automatic test_pass_through;
    int lat; logic [2:0] gle; logic pl;
    run_op(32'h10000000, 32'h1FFFFFFF, lat, gle, pl);
    nvec++;
    if (gle !== 3'b010) begin nfail++; $display("FAIL passthru_gle: got %b expected 010", gle); end
  endtask

  task automatic test_stall;
    int k; logic [2:0] gle;
    @(negedge clk);
    start = 1'b1; en = 1'b1; a = 32'd5; b = 32'd3;
    @(negedge clk);
    start = 1'b0; a = '0; b = 32'hFFFFFFFF;
    k = 0;
    en = 1'b0;
    while (!done && k < 100) begin
      @(negedge clk);
      k++;
      nvec++;
      if (!done && busy !== 1'b1) begin
        nfail++; $display("FAIL stall_busy: got %b expected 1 at edge %0d", busy, k);
      end
      en = ~en;
    end
    gle = {g, l, e};
    nvec++;
    if (!done || k !== 16) begin nfail++; $display("FAIL stall_latency: got %0d expected 16", done ? k : -1); end
    nvec++;
    if (gle !== 3'b100) begin nfail++; $display("FAIL stall_gle: got %b expected 100", gle); end
    en = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_abort;
    int lat; logic [2:0] gle; logic pl;
    @(negedge clk);
    start = 1'b1; en = 1'b1; a = 32'd1; b = 32'd2;
    repeat (3) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst = 1'b1; start = 1'b1;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    nvec++;
    if ({busy, done, g, l, e} !== 5'b00000) begin
      nfail++; $display("FAIL abort_outputs: got busy,done,g,l,e=%b expected 00000", {busy, done, g, l, e});
    end
    repeat (10) @(negedge clk);
    nvec++;
    if ({busy, done} !== 2'b00) begin
      nfail++; $display("FAIL abort_no_done: got busy,done=%b expected 00", {busy, done});
    end
    run_op(32'hFFFFFFFF, 32'hFFFFFFFE, lat, gle, pl);
    nvec++;
    if (lat !== 8 || gle !== 3'b100) begin
      nfail++; $display("FAIL abort_restart: got lat=%0d gle=%b expected lat=8 gle=100", lat, gle);
    end
  endtask

  task automatic test_sign_and_busy_start;
    int k; logic [2:0] gle; logic [2:0] exp_gle;
`ifdef COMP_SIGNED_EN
    exp_gle = 3'b010;
`else
    exp_gle = 3'b100;
`endif
    @(negedge clk);
    start = 1'b1; en = 1'b1; a = 32'h80000000; b = 32'h00000001;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (!done && k < 100) begin
      if (k == 3) begin
        start = 1'b1; a = 32'h00000001; b = 32'h80000000;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      k++;
      if (k == 5) begin
        nvec++;
        if ({g, l, e} !== 3'b100) begin
          nfail++; $display("FAIL old_result_hold: got %b expected 100", {g, l, e});
        end
      end
    end
    start = 1'b0;
    gle = {g, l, e};
    nvec++;
    if (!done || k !== 8) begin nfail++; $display("FAIL busy_start_latency: got %0d expected 8", done ? k : -1); end
    nvec++;
    if (gle !== exp_gle) begin nfail++; $display("FAIL sign_compare: got %b expected %b", gle, exp_gle); end
    repeat (3) @(negedge clk);
    nvec++;
    if ({busy, done} !== 2'b00) begin
      nfail++; $display("FAIL no_queued_run: got busy,done=%b expected 00", {busy, done});
    end
  endtask

  initial begin
    test_reset();
    test_equal();
    test_high_overrides();
    test_pass_through();
    test_stall();
    test_abort();
    test_sign_and_busy_start();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
